// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Arbitrates the instruction-cache and data-cache miss ports onto a single
// main-memory request port, then routes the memory response back to the
// cache that owns the transaction.
//
// Each cache has one pending slot. The data cache normally wins, but after
// STARVE_MAX consecutive data-cache grants with an instruction miss waiting,
// the instruction cache is granted instead. A grant waits REQ_LAT idle
// cycles before the memory request is driven. Only one transaction is in
// flight at a time, and the owner is locked from grant until its response.
//
// Ports
//   clock, reset_n            sole clock (rising edge), async active-low reset
//   icache_req_valid/addr     one-cycle instruction-cache miss pulse
//   dcache_req_valid/addr/    one-cycle data-cache miss or write-back pulse
//     is_store/data
//   rsp_valid/cache_id/       one-cycle response to the core (0 = I$, 1 = D$),
//     data/bus_error          data and error held until the next response
//   mm_req_valid/ready/addr/  valid/ready request to main memory
//     is_store/data
//   mm_rsp_valid/data/        one-cycle memory completion
//     bus_error
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 128,
  parameter int REQ_LAT    = 4,
  parameter int STARVE_MAX = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              icache_req_valid,
  input  logic [ADDR_W-1:0] icache_req_addr,
  input  logic              dcache_req_valid,
  input  logic [ADDR_W-1:0] dcache_req_addr,
  input  logic              dcache_req_is_store,
  input  logic [LINE_W-1:0] dcache_req_data,
  output logic              rsp_valid,
  output logic              rsp_cache_id,
  output logic [LINE_W-1:0] rsp_data,
  output logic              rsp_bus_error,
  output logic              mm_req_valid,
  input  logic              mm_req_ready,
  output logic [ADDR_W-1:0] mm_req_addr,
  output logic              mm_req_is_store,
  output logic [LINE_W-1:0] mm_req_data,
  input  logic              mm_rsp_valid,
  input  logic [LINE_W-1:0] mm_rsp_data,
  input  logic              mm_rsp_bus_error
);

  localparam int CNT_W = (REQ_LAT > 1) ? $clog2(REQ_LAT) : 1;
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LAT,
    ISSUE,
    WAIT_RSP,
    RESP
  } state_t;

  state_t state_q;

  // Pending slots
  logic              iValid_q;
  logic [ADDR_W-1:0] iAddr_q;
  logic              dValid_q;
  logic [ADDR_W-1:0] dAddr_q;
  logic              dStore_q;
  logic [LINE_W-1:0] dData_q;

  // Arbitration state
  logic             owner_q;
  logic [CNT_W-1:0] latCnt_q;
  logic [STV_W-1:0] starve_q;

  // Registered outputs
  logic              rspValid_q;
  logic              rspCacheId_q;
  logic [LINE_W-1:0] rspData_q;
  logic              rspBusError_q;
  logic              mmReqValid_q;
  logic [ADDR_W-1:0] mmReqAddr_q;
  logic              mmReqIsStore_q;
  logic [LINE_W-1:0] mmReqData_q;

  logic grantI_d;
  logic grantD_d;
  logic selD_d;
  logic iClear;
  logic dClear;

  // The owning slot empties during its RESP cycle.
  assign iClear = (state_q == RESP) && !owner_q;
  assign dClear = (state_q == RESP) &&  owner_q;

  // Grant decision for IDLE. selD_d picks which slot feeds the memory
  // payload: the fresh grant when issuing straight from IDLE, otherwise
  // the latched owner.
  always_comb begin
    grantI_d = iValid_q && (!dValid_q || (starve_q == STV_W'(STARVE_MAX)));
    grantD_d = dValid_q && !grantI_d;
    selD_d   = (state_q == IDLE) ? grantD_d : owner_q;
  end

  // A pulse fills an empty slot, or one being cleared this cycle (the new
  // request wins over the clear). A pulse into a full slot is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      iValid_q <= 1'b0;
      iAddr_q  <= '0;
      dValid_q <= 1'b0;
      dAddr_q  <= '0;
      dStore_q <= 1'b0;
      dData_q  <= '0;
    end else begin
      if (icache_req_valid && (!iValid_q || iClear)) begin
        iValid_q <= 1'b1;
        iAddr_q  <= icache_req_addr;
      end else if (iClear) begin
        iValid_q <= 1'b0;
      end

      if (dcache_req_valid && (!dValid_q || dClear)) begin
        dValid_q <= 1'b1;
        dAddr_q  <= dcache_req_addr;
        dStore_q <= dcache_req_is_store;
        dData_q  <= dcache_req_data;
      end else if (dClear) begin
        dValid_q <= 1'b0;
      end
    end
  end

  // Transaction FSM with all outputs registered. The memory payload is
  // loaded on entry to ISSUE and zeroed on acceptance, so it is stable
  // while ready is low and zero in every other state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      latCnt_q       <= '0;
      starve_q       <= '0;
      rspValid_q     <= 1'b0;
      rspCacheId_q   <= 1'b0;
      rspData_q      <= '0;
      rspBusError_q  <= 1'b0;
      mmReqValid_q   <= 1'b0;
      mmReqAddr_q    <= '0;
      mmReqIsStore_q <= 1'b0;
      mmReqData_q    <= '0;
    end else begin
      rspValid_q <= 1'b0;

      // The guard only counts while an instruction miss is waiting.
      if (!iValid_q) begin
        starve_q <= '0;
      end

      case (state_q)
        IDLE: begin
          if (grantI_d || grantD_d) begin
            owner_q  <= grantD_d;
            latCnt_q <= '0;
            if (grantI_d) begin
              starve_q <= '0;
            end else if (iValid_q) begin
              starve_q <= starve_q + 1'b1;
            end
            if (REQ_LAT == 0) begin
              state_q        <= ISSUE;
              mmReqValid_q   <= 1'b1;
              mmReqAddr_q    <= selD_d ? dAddr_q : iAddr_q;
              mmReqIsStore_q <= selD_d && dStore_q;
              mmReqData_q    <= selD_d ? dData_q : '0;
            end else begin
              state_q <= WAIT_LAT;
            end
          end
        end

        WAIT_LAT: begin
          if (latCnt_q == CNT_W'(REQ_LAT - 1)) begin
            state_q        <= ISSUE;
            mmReqValid_q   <= 1'b1;
            mmReqAddr_q    <= selD_d ? dAddr_q : iAddr_q;
            mmReqIsStore_q <= selD_d && dStore_q;
            mmReqData_q    <= selD_d ? dData_q : '0;
          end else begin
            latCnt_q <= latCnt_q + 1'b1;
          end
        end

        ISSUE: begin
          if (mm_req_ready) begin
            state_q        <= WAIT_RSP;
            mmReqValid_q   <= 1'b0;
            mmReqAddr_q    <= '0;
            mmReqIsStore_q <= 1'b0;
            mmReqData_q    <= '0;
          end
        end

        WAIT_RSP: begin
          if (mm_rsp_valid) begin
            state_q       <= RESP;
            rspValid_q    <= 1'b1;
            rspCacheId_q  <= owner_q;
            rspData_q     <= mm_rsp_data;
            rspBusError_q <= mm_rsp_bus_error;
          end
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid       = rspValid_q;
  assign rsp_cache_id    = rspCacheId_q;
  assign rsp_data        = rspData_q;
  assign rsp_bus_error   = rspBusError_q;
  assign mm_req_valid    = mmReqValid_q;
  assign mm_req_addr     = mmReqAddr_q;
  assign mm_req_is_store = mmReqIsStore_q;
  assign mm_req_data     = mmReqData_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with REQ_LAT = 4 and STARVE_MAX = 2.
// A table of single-cache transactions is applied in a loop; hand-written
// sequences cover simultaneous requests, the starvation guard, a ready
// stall and reset in the middle of a transaction.
module tb_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int LINE_W     = 128;
  localparam int REQ_LAT    = 4;
  localparam int STARVE_MAX = 2;

  logic              clock;
  logic              reset_n;
  logic              icache_req_valid;
  logic [ADDR_W-1:0] icache_req_addr;
  logic              dcache_req_valid;
  logic [ADDR_W-1:0] dcache_req_addr;
  logic              dcache_req_is_store;
  logic [LINE_W-1:0] dcache_req_data;
  logic              rsp_valid;
  logic              rsp_cache_id;
  logic [LINE_W-1:0] rsp_data;
  logic              rsp_bus_error;
  logic              mm_req_valid;
  logic              mm_req_ready;
  logic [ADDR_W-1:0] mm_req_addr;
  logic              mm_req_is_store;
  logic [LINE_W-1:0] mm_req_data;
  logic              mm_rsp_valid;
  logic [LINE_W-1:0] mm_rsp_data;
  logic              mm_rsp_bus_error;

  mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .LINE_W    (LINE_W),
    .REQ_LAT   (REQ_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .icache_req_valid   (icache_req_valid),
    .icache_req_addr    (icache_req_addr),
    .dcache_req_valid   (dcache_req_valid),
    .dcache_req_addr    (dcache_req_addr),
    .dcache_req_is_store(dcache_req_is_store),
    .dcache_req_data    (dcache_req_data),
    .rsp_valid          (rsp_valid),
    .rsp_cache_id       (rsp_cache_id),
    .rsp_data           (rsp_data),
    .rsp_bus_error      (rsp_bus_error),
    .mm_req_valid       (mm_req_valid),
    .mm_req_ready       (mm_req_ready),
    .mm_req_addr        (mm_req_addr),
    .mm_req_is_store    (mm_req_is_store),
    .mm_req_data        (mm_req_data),
    .mm_rsp_valid       (mm_rsp_valid),
    .mm_rsp_data        (mm_rsp_data),
    .mm_rsp_bus_error   (mm_rsp_bus_error)
  );

  typedef struct {
    bit                isD;
    logic [ADDR_W-1:0] addr;
    bit                isStore;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] memData;
    bit                busErr;
    int                expIssue;
    int                expRsp;
  } vec_t;

  int total;
  int bad;
  int cycle;
  int acceptCnt;

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts memory handshakes as the memory would see them.
  always @(posedge clock) begin
    if (reset_n && mm_req_valid && mm_req_ready) acceptCnt++;
  end

  // Hard stop in case the design wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                             input logic [LINE_W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cycle++;
  endtask

  task automatic waitIssue(input string name);
    int n;
    n = 0;
    while (mm_req_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (mm_req_valid !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got no mm_req_valid required issue", name);
    end
  endtask

  // Runs one isolated transaction with ready = 1 and a 1-cycle memory.
  task automatic applyStimulus(input vec_t v, input string name);
    cycle = 0;
    if (v.isD) begin
      dcache_req_valid    = 1'b1;
      dcache_req_addr     = v.addr;
      dcache_req_is_store = v.isStore;
      dcache_req_data     = v.wdata;
    end else begin
      icache_req_valid = 1'b1;
      icache_req_addr  = v.addr;
    end
    tick();
    icache_req_valid = 1'b0;
    dcache_req_valid = 1'b0;
    waitIssue({name, " issue"});
    checkOutput({name, " issue cycle"}, LINE_W'(cycle), LINE_W'(v.expIssue));
    checkOutput({name, " mm addr"}, LINE_W'(mm_req_addr), LINE_W'(v.addr));
    checkOutput({name, " mm store"}, LINE_W'(mm_req_is_store), LINE_W'(v.isStore));
    if (v.isStore) checkOutput({name, " mm data"}, mm_req_data, v.wdata);
    tick();
    checkOutput({name, " mm valid drop"}, LINE_W'(mm_req_valid), '0);
    mm_rsp_valid     = 1'b1;
    mm_rsp_data      = v.memData;
    mm_rsp_bus_error = v.busErr;
    tick();
    mm_rsp_valid     = 1'b0;
    mm_rsp_data      = '0;
    mm_rsp_bus_error = 1'b0;
    checkOutput({name, " rsp valid"}, LINE_W'(rsp_valid), LINE_W'(1));
    checkOutput({name, " rsp cycle"}, LINE_W'(cycle), LINE_W'(v.expRsp));
    checkOutput({name, " rsp id"}, LINE_W'(rsp_cache_id), LINE_W'(v.isD));
    checkOutput({name, " rsp err"}, LINE_W'(rsp_bus_error), LINE_W'(v.busErr));
    if (!v.isStore) checkOutput({name, " rsp data"}, rsp_data, v.memData);
    tick();
    checkOutput({name, " rsp one cycle"}, LINE_W'(rsp_valid), '0);
    if (!v.isStore) checkOutput({name, " rsp data hold"}, rsp_data, v.memData);
    tick();
  endtask

  // Answers the request currently in ISSUE (ready = 1) and returns in the
  // RESP cycle.
  task automatic serveOne(input logic [LINE_W-1:0] data, input bit err);
    tick();
    mm_rsp_valid     = 1'b1;
    mm_rsp_data      = data;
    mm_rsp_bus_error = err;
    tick();
    mm_rsp_valid     = 1'b0;
    mm_rsp_bus_error = 1'b0;
  endtask

  initial begin
    vec_t vecs[5];
    vec_t fresh;
    bit   expOrder[6];
    int   accBase;
    int   seen;

    total = 0;
    bad   = 0;
    cycle = 0;
    acceptCnt = 0;

    vecs[0] = '{isD: 1'b0, addr: 32'h0000_1000, isStore: 1'b0, wdata: '0,
                memData: {4{32'h1111_2222}}, busErr: 1'b0, expIssue: 6, expRsp: 8};
    vecs[1] = '{isD: 1'b1, addr: 32'h0000_2000, isStore: 1'b0, wdata: '0,
                memData: {4{32'hDEAD_BEEF}}, busErr: 1'b0, expIssue: 6, expRsp: 8};
    vecs[2] = '{isD: 1'b1, addr: 32'h0000_3000, isStore: 1'b1, wdata: {16{8'hA5}},
                memData: '0, busErr: 1'b0, expIssue: 6, expRsp: 8};
    vecs[3] = '{isD: 1'b1, addr: 32'hFFFF_FFC0, isStore: 1'b0, wdata: '0,
                memData: {4{32'h0BAD_0BAD}}, busErr: 1'b1, expIssue: 6, expRsp: 8};
    vecs[4] = '{isD: 1'b0, addr: 32'h0000_4040, isStore: 1'b0, wdata: '0,
                memData: {2{64'h0123_4567_89AB_CDEF}}, busErr: 1'b1, expIssue: 6, expRsp: 8};
    fresh   = '{isD: 1'b0, addr: 32'h0000_8000, isStore: 1'b0, wdata: '0,
                memData: {4{32'h5A5A_0F0F}}, busErr: 1'b0, expIssue: 6, expRsp: 8};

    reset_n             = 1'b0;
    icache_req_valid    = 1'b0;
    icache_req_addr     = '0;
    dcache_req_valid    = 1'b0;
    dcache_req_addr     = '0;
    dcache_req_is_store = 1'b0;
    dcache_req_data     = '0;
    mm_req_ready        = 1'b1;
    mm_rsp_valid        = 1'b0;
    mm_rsp_data         = '0;
    mm_rsp_bus_error    = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("reset rsp_valid", LINE_W'(rsp_valid), '0);
    checkOutput("reset mm_req_valid", LINE_W'(mm_req_valid), '0);
    checkOutput("reset rsp_data", rsp_data, '0);
    checkOutput("reset mm_req_addr", LINE_W'(mm_req_addr), '0);
    #2;
    reset_n = 1'b1;
    tick();

    // Table of isolated transactions
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Simultaneous I$ load and D$ store: D$ first, I$ after the D$ RESP
    cycle = 0;
    icache_req_valid    = 1'b1;
    icache_req_addr     = 32'h0000_1000;
    dcache_req_valid    = 1'b1;
    dcache_req_addr     = 32'h0000_3000;
    dcache_req_is_store = 1'b1;
    dcache_req_data     = {16{8'hA5}};
    tick();
    icache_req_valid = 1'b0;
    dcache_req_valid = 1'b0;
    waitIssue("simul D issue");
    checkOutput("simul D issue cycle", LINE_W'(cycle), LINE_W'(6));
    checkOutput("simul D addr", LINE_W'(mm_req_addr), LINE_W'(32'h0000_3000));
    checkOutput("simul D store", LINE_W'(mm_req_is_store), LINE_W'(1));
    checkOutput("simul D data", mm_req_data, {16{8'hA5}});
    serveOne('0, 1'b0);
    checkOutput("simul D rsp valid", LINE_W'(rsp_valid), LINE_W'(1));
    checkOutput("simul D rsp id", LINE_W'(rsp_cache_id), LINE_W'(1));
    checkOutput("simul D rsp cycle", LINE_W'(cycle), LINE_W'(8));
    waitIssue("simul I issue");
    checkOutput("simul I issue cycle", LINE_W'(cycle), LINE_W'(14));
    checkOutput("simul I addr", LINE_W'(mm_req_addr), LINE_W'(32'h0000_1000));
    checkOutput("simul I store", LINE_W'(mm_req_is_store), '0);
    serveOne({4{32'hCAFE_F00D}}, 1'b0);
    checkOutput("simul I rsp valid", LINE_W'(rsp_valid), LINE_W'(1));
    checkOutput("simul I rsp id", LINE_W'(rsp_cache_id), '0);
    checkOutput("simul I rsp data", rsp_data, {4{32'hCAFE_F00D}});
    checkOutput("simul I rsp cycle", LINE_W'(cycle), LINE_W'(16));
    tick();
    tick();

    // Starvation guard: D$ refilled every RESP with I$ pending
    expOrder = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    icache_req_valid    = 1'b1;
    icache_req_addr     = 32'h0000_1000;
    dcache_req_valid    = 1'b1;
    dcache_req_addr     = 32'h0000_3000;
    dcache_req_is_store = 1'b0;
    dcache_req_data     = '0;
    tick();
    icache_req_valid = 1'b0;
    dcache_req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bit servedD;
      waitIssue($sformatf("starve issue %0d", k));
      servedD = (mm_req_addr == 32'h0000_3000);
      checkOutput($sformatf("starve grant %0d", k), LINE_W'(servedD), LINE_W'(expOrder[k]));
      serveOne({4{32'h0000_0000 + 32'(k)}}, 1'b0);
      checkOutput($sformatf("starve rsp id %0d", k), LINE_W'(rsp_cache_id), LINE_W'(expOrder[k]));
      // Refill the slot being served, except where the sequence no longer
      // needs it, so both slots are empty at the end.
      if (k != 4 && k != 5) begin
        if (servedD) dcache_req_valid = 1'b1;
        else         icache_req_valid = 1'b1;
      end
      tick();
      icache_req_valid = 1'b0;
      dcache_req_valid = 1'b0;
    end
    tick();
    tick();

    // Ready stall with an ignored pulse into the busy D$ slot
    mm_req_ready = 1'b0;
    accBase = acceptCnt;
    dcache_req_valid    = 1'b1;
    dcache_req_addr     = 32'h0000_5000;
    dcache_req_is_store = 1'b0;
    tick();
    dcache_req_valid = 1'b0;
    waitIssue("stall issue");
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall valid %0d", i), LINE_W'(mm_req_valid), LINE_W'(1));
      checkOutput($sformatf("stall addr %0d", i), LINE_W'(mm_req_addr), LINE_W'(32'h0000_5000));
      if (i == 1) begin
        dcache_req_valid = 1'b1;
        dcache_req_addr  = 32'h0000_6000;
      end
      tick();
      dcache_req_valid = 1'b0;
    end
    mm_req_ready = 1'b1;
    checkOutput("stall valid at ready", LINE_W'(mm_req_valid), LINE_W'(1));
    serveOne({4{32'h7777_8888}}, 1'b1);
    checkOutput("stall rsp valid", LINE_W'(rsp_valid), LINE_W'(1));
    checkOutput("stall rsp err", LINE_W'(rsp_bus_error), LINE_W'(1));
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (mm_req_valid === 1'b1) seen++;
    end
    checkOutput("stall no reissue", LINE_W'(seen), '0);
    checkOutput("stall accept count", LINE_W'(acceptCnt - accBase), LINE_W'(1));

    // Reset during WAIT_RSP
    icache_req_valid = 1'b1;
    icache_req_addr  = 32'h0000_7000;
    tick();
    icache_req_valid = 1'b0;
    waitIssue("reset issue");
    tick();
    reset_n = 1'b0;
    #1;
    checkOutput("midreset rsp_valid", LINE_W'(rsp_valid), '0);
    checkOutput("midreset rsp_data", rsp_data, '0);
    checkOutput("midreset rsp_err", LINE_W'(rsp_bus_error), '0);
    checkOutput("midreset rsp_id", LINE_W'(rsp_cache_id), '0);
    checkOutput("midreset mm_req_valid", LINE_W'(mm_req_valid), '0);
    #2;
    reset_n = 1'b1;
    tick();
    mm_rsp_valid = 1'b1;
    mm_rsp_data  = {4{32'hBADD_CAFE}};
    tick();
    mm_rsp_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid === 1'b1 || mm_req_valid === 1'b1) seen++;
      tick();
    end
    checkOutput("stale rsp ignored", LINE_W'(seen), '0);
    applyStimulus(fresh, "post reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
